result_wr_collector: RTL and testbench

RESULT_WR_COLLECTOR -- requirements
Module: result_wr_collector

---
 rtl/result_wr_collector.sv | 212 +++++++++++++++++++++
 tb/tb_result_wr_collector.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_wr_collector.sv
// -----------------------------------------------------------------------------
// result_wr_collector
//
// Gathers result writes from three independent producer channels into a
// single shared result memory port. Each channel has its own small FIFO so
// that producers never see backpressure. A round-robin arbiter drains one
// entry per cycle whenever the memory is ready. The memory port outputs are
// registered. If a push arrives while its FIFO is full, the entry is dropped
// and a sticky per-channel overflow flag is set.
//
// Ports
//   clk                  single clock, rising edge
//   rst                  asynchronous active-low reset
//   in_we_k              per-channel write strobe (k = 0..2)
//   in_addr_k [ADDR_W]   per-channel result address
//   in_y_k    [DATA_W]   per-channel result byte
//   mem_ready            memory accepts a write next cycle
//   clr_ovf              synchronous pulse clearing all overflow flags
//   mem_we               registered write strobe
//   mem_addr  [ADDR_W+2] registered {channel, addr}
//   mem_data  [DATA_W]   registered write data
//   overflow_k           sticky drop flag per channel
//   busy                 any FIFO non-empty or mem_we high
// -----------------------------------------------------------------------------
module result_wr_collector #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_we_0,
    input  logic                in_we_1,
    input  logic                in_we_2,
    input  logic [ADDR_W-1:0]   in_addr_0,
    input  logic [ADDR_W-1:0]   in_addr_1,
    input  logic [ADDR_W-1:0]   in_addr_2,
    input  logic [DATA_W-1:0]   in_y_0,
    input  logic [DATA_W-1:0]   in_y_1,
    input  logic [DATA_W-1:0]   in_y_2,
    input  logic                mem_ready,
    input  logic                clr_ovf,
    output logic                mem_we,
    output logic [ADDR_W+1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic                overflow_0,
    output logic                overflow_1,
    output logic                overflow_2,
    output logic                busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Per-channel FIFO storage and bookkeeping
    logic [ADDR_W-1:0] r_fifo_addr [3][FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [3][FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [3];
    logic [PTR_W-1:0]  r_rd_ptr [3];
    logic [CNT_W-1:0]  r_cnt    [3];

    logic [1:0]        r_rr_ptr;
    logic [2:0]        r_ovf;
    logic              r_mem_we;
    logic [ADDR_W+1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;

    // Channel-indexed views of the flat input ports
    logic [2:0]        w_we;
    logic [ADDR_W-1:0] w_in_addr [3];
    logic [DATA_W-1:0] w_in_data [3];

    logic [2:0]        w_nonempty;
    logic [2:0]        w_full;
    logic [2:0]        w_pop;
    logic [2:0]        w_push;
    logic [2:0]        w_drop;

    logic              w_gnt_vld;
    logic [1:0]        w_gnt_ch;
    logic [1:0]        w_cand_1;
    logic [1:0]        w_cand_2;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    function automatic logic [1:0] ch_inc(input logic [1:0] c);
        return (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign w_we         = {in_we_2, in_we_1, in_we_0};
    assign w_in_addr[0] = in_addr_0;
    assign w_in_addr[1] = in_addr_1;
    assign w_in_addr[2] = in_addr_2;
    assign w_in_data[0] = in_y_0;
    assign w_in_data[1] = in_y_1;
    assign w_in_data[2] = in_y_2;

    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        for (int k = 0; k < 3; k++) begin
            w_nonempty[k] = (r_cnt[k] != '0);
            w_full[k]     = (r_cnt[k] == CNT_FULL);
        end
    end

    // Round-robin search order: rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
    // Uses pre-edge occupancy, so an entry pushed this cycle is never
    // granted in the same cycle.
    assign w_cand_1 = ch_inc(r_rr_ptr);
    assign w_cand_2 = ch_inc(w_cand_1);

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = 2'd0;
        if (mem_ready) begin
            if (w_nonempty[r_rr_ptr]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = r_rr_ptr;
            end else if (w_nonempty[w_cand_1]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_cand_1;
            end else if (w_nonempty[w_cand_2]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_cand_2;
            end
        end
    end

    assign w_head_addr = r_fifo_addr[w_gnt_ch][r_rd_ptr[w_gnt_ch]];
    assign w_head_data = r_fifo_data[w_gnt_ch][r_rd_ptr[w_gnt_ch]];

    // A full FIFO still accepts a push when it is being popped at the same
    // edge, since the slot being read frees up as the new one is written.
    always_comb begin
        w_pop  = '0;
        w_push = '0;
        w_drop = '0;
        for (int k = 0; k < 3; k++) begin
            w_pop[k]  = w_gnt_vld && (w_gnt_ch == 2'(k));
            w_push[k] = w_we[k] && (!w_full[k] || w_pop[k]);
            w_drop[k] = w_we[k] && w_full[k] && !w_pop[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_cnt[k]    <= '0;
            end
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (w_push[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                    2'b01:   r_cnt[k] <= r_cnt[k] - CNT_W'(1);
                    default: r_cnt[k] <= r_cnt[k];
                endcase
                // A fresh drop takes priority over a clear in the same cycle.
                if (w_drop[k]) begin
                    r_ovf[k] <= 1'b1;
                end else if (clr_ovf) begin
                    r_ovf[k] <= 1'b0;
                end
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (w_push[k]) begin
                r_fifo_addr[k][r_wr_ptr[k]] <= w_in_addr[k];
                r_fifo_data[k][r_wr_ptr[k]] <= w_in_data[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= 2'd0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr   <= ch_inc(w_gnt_ch);
            r_mem_we   <= 1'b1;
            r_mem_addr <= {w_gnt_ch, w_head_addr};
            r_mem_data <= w_head_data;
        end else begin
            r_mem_we   <= 1'b0;
        end
    end

    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign overflow_0 = r_ovf[0];
    assign overflow_1 = r_ovf[1];
    assign overflow_2 = r_ovf[2];
    assign busy       = (|w_nonempty) | r_mem_we;

endmodule

// File: tb/tb_result_wr_collector.sv
// -----------------------------------------------------------------------------
// tb_result_wr_collector
//
// Directed bench for result_wr_collector: reset state, single write,
// simultaneous three-channel arbitration, stall with overflow and clear,
// full push+pop on one FIFO, mid-run reset, and a long periodic stream whose
// memory image is compared against values computed here.
// -----------------------------------------------------------------------------
module tb_result_wr_collector;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int N_STREAM = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_we_0, in_we_1, in_we_2;
    logic [ADDR_W-1:0] in_addr_0, in_addr_1, in_addr_2;
    logic [DATA_W-1:0] in_y_0, in_y_1, in_y_2;
    logic              mem_ready;
    logic              clr_ovf;
    logic              mem_we;
    logic [ADDR_W+1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              overflow_0, overflow_1, overflow_2;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    logic              cap_en = 1'b0;
    logic [DATA_W-1:0] img [3][N_STREAM];
    int                wcnt [3];

    result_wr_collector #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_we_0    (in_we_0),
        .in_we_1    (in_we_1),
        .in_we_2    (in_we_2),
        .in_addr_0  (in_addr_0),
        .in_addr_1  (in_addr_1),
        .in_addr_2  (in_addr_2),
        .in_y_0     (in_y_0),
        .in_y_1     (in_y_1),
        .in_y_2     (in_y_2),
        .mem_ready  (mem_ready),
        .clr_ovf    (clr_ovf),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .overflow_0 (overflow_0),
        .overflow_1 (overflow_1),
        .overflow_2 (overflow_2),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs set before the call are applied at that edge
    // and outputs are sampled 1 time unit later.
    task automatic tick();
        logic [1:0] ch;
        @(posedge clk);
        #1;
        if (cap_en && mem_we) begin
            ch = mem_addr[ADDR_W+1:ADDR_W];
            if (ch < 2'd3 && mem_addr[ADDR_W-1:0] < 16'(N_STREAM)) begin
                img[ch][mem_addr[ADDR_W-1:0]] = mem_data;
                wcnt[ch]++;
            end
        end
    endtask

    task automatic set_in(input int ch, input logic we, input logic [15:0] a, input logic [7:0] y);
        case (ch)
            0: begin in_we_0 = we; in_addr_0 = a; in_y_0 = y; end
            1: begin in_we_1 = we; in_addr_1 = a; in_y_1 = y; end
            default: begin in_we_2 = we; in_addr_2 = a; in_y_2 = y; end
        endcase
    endtask

    task automatic idle_all();
        set_in(0, 1'b0, 16'h0, 8'h0);
        set_in(1, 1'b0, 16'h0, 8'h0);
        set_in(2, 1'b0, 16'h0, 8'h0);
    endtask

    function automatic logic [7:0] stream_y(input int k, input int i);
        return 8'(i * 7 + k * 13 + 1);
    endfunction

    initial begin
        rst = 1'b0;
        idle_all();
        mem_ready = 1'b1;
        clr_ovf = 1'b0;
        for (int k = 0; k < 3; k++) wcnt[k] = 0;

        // Reset state
        #2;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_data", 32'(mem_data), 32'h0);
        chk("rst_ovf", 32'({overflow_2, overflow_1, overflow_0}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        tick();
        tick();
        rst = 1'b1;

        // Simultaneous writes on all channels, rr_ptr starts at 0
        set_in(0, 1'b1, 16'h0005, 8'h11);
        set_in(1, 1'b1, 16'h0005, 8'h22);
        set_in(2, 1'b1, 16'h0005, 8'h33);
        tick();
        idle_all();
        chk("sim_e1_we", 32'(mem_we), 32'h0);
        chk("sim_e1_busy", 32'(busy), 32'h1);
        tick();
        chk("sim_e2_we", 32'(mem_we), 32'h1);
        chk("sim_e2_addr", 32'(mem_addr), 32'h00005);
        chk("sim_e2_data", 32'(mem_data), 32'h11);
        tick();
        chk("sim_e3_addr", 32'(mem_addr), 32'h10005);
        chk("sim_e3_data", 32'(mem_data), 32'h22);
        tick();
        chk("sim_e4_addr", 32'(mem_addr), 32'h20005);
        chk("sim_e4_data", 32'(mem_data), 32'h33);
        chk("sim_e4_we", 32'(mem_we), 32'h1);
        tick();
        chk("sim_e5_we", 32'(mem_we), 32'h0);
        chk("sim_e5_busy", 32'(busy), 32'h0);
        chk("sim_e5_addr_hold", 32'(mem_addr), 32'h20005);

        // Single write on channel 1 (rr_ptr back at 0)
        set_in(1, 1'b1, 16'h0010, 8'hAB);
        tick();
        set_in(1, 1'b0, 16'h0, 8'h0);
        chk("single_e1_we", 32'(mem_we), 32'h0);
        chk("single_e1_busy", 32'(busy), 32'h1);
        tick();
        chk("single_e2_we", 32'(mem_we), 32'h1);
        chk("single_e2_addr", 32'(mem_addr), 32'h10010);
        chk("single_e2_data", 32'(mem_data), 32'hAB);
        tick();
        chk("single_e3_we", 32'(mem_we), 32'h0);
        chk("single_e3_busy", 32'(busy), 32'h0);

        // Stall: 5 pushes to channel 0, fifth dropped
        mem_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 1'b1, 16'(16'h0200 + i), 8'(i));
            tick();
            chk("stall_ovf0", 32'(overflow_0), (i == 5) ? 32'h1 : 32'h0);
            chk("stall_we", 32'(mem_we), 32'h0);
        end
        // Another drop coinciding with a clear: the drop wins
        set_in(0, 1'b1, 16'h0206, 8'h06);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        set_in(0, 1'b0, 16'h0, 8'h0);
        chk("clr_vs_drop_ovf0", 32'(overflow_0), 32'h1);
        mem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("drain0_we", 32'(mem_we), 32'h1);
            chk("drain0_addr", 32'(mem_addr), 32'h00200 + 32'(i));
            chk("drain0_data", 32'(mem_data), 32'(i));
        end
        tick();
        chk("drain0_end_we", 32'(mem_we), 32'h0);
        chk("drain0_end_busy", 32'(busy), 32'h0);
        chk("drain0_ovf_sticky", 32'(overflow_0), 32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf0", 32'(overflow_0), 32'h0);

        // Full channel 2 with simultaneous push and pop
        mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_in(2, 1'b1, 16'(16'h0100 + i), 8'(8'hA0 + i));
            tick();
        end
        mem_ready = 1'b1;
        set_in(2, 1'b1, 16'h0105, 8'hA5);
        tick();
        set_in(2, 1'b0, 16'h0, 8'h0);
        chk("fullpp_we", 32'(mem_we), 32'h1);
        chk("fullpp_data", 32'(mem_data), 32'hA1);
        chk("fullpp_addr", 32'(mem_addr), 32'h20101);
        chk("fullpp_ovf2", 32'(overflow_2), 32'h0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("fullpp_drain_we", 32'(mem_we), 32'h1);
            chk("fullpp_drain_addr", 32'(mem_addr), 32'h20100 + 32'(i));
            chk("fullpp_drain_data", 32'(mem_data), 32'hA0 + 32'(i));
        end
        tick();
        chk("fullpp_end_we", 32'(mem_we), 32'h0);
        chk("fullpp_end_ovf2", 32'(overflow_2), 32'h0);

        // Reset mid-run with entries queued and a write in flight
        mem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_in(1, 1'b1, 16'(16'h0300 + i), 8'(8'hC0 + i));
            tick();
        end
        set_in(1, 1'b0, 16'h0, 8'h0);
        chk("midrst_busy_pre", 32'(busy), 32'h1);
        mem_ready = 1'b1;
        tick();
        chk("midrst_we_pre", 32'(mem_we), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_we", 32'(mem_we), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_addr", 32'(mem_addr), 32'h0);
        tick();
        rst = 1'b1;
        // First edge after release accepts a push
        set_in(0, 1'b1, 16'h0777, 8'h5A);
        tick();
        set_in(0, 1'b0, 16'h0, 8'h0);
        chk("postrst_busy", 32'(busy), 32'h1);
        tick();
        chk("postrst_we", 32'(mem_we), 32'h1);
        chk("postrst_addr", 32'(mem_addr), 32'h00777);
        chk("postrst_data", 32'(mem_data), 32'h5A);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("postrst_no_stale_we", 32'(mem_we), 32'h0);
            chk("postrst_no_stale_busy", 32'(busy), 32'h0);
        end

        // Sustained stream at a 38-cycle cadence on all channels
        cap_en = 1'b1;
        for (int i = 0; i < N_STREAM; i++) begin
            for (int k = 0; k < 3; k++) set_in(k, 1'b1, 16'(i), stream_y(k, i));
            tick();
            idle_all();
            repeat (37) tick();
        end
        repeat (4) tick();
        cap_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stream_count", 32'(wcnt[k]), 32'(N_STREAM));
            for (int i = 0; i < N_STREAM; i++) begin
                chk("stream_img", 32'(img[k][i]), 32'(stream_y(k, i)));
            end
        end
        chk("stream_ovf", 32'({overflow_2, overflow_1, overflow_0}), 32'h0);
        chk("stream_busy", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
